// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - frame_buffer read/swap port and VGA output bundle for vga_scanout
interface vga_scanout_if;
  logic        swap_request;
  logic        swap;
  logic        swap_done;
  logic [18:0] read_addr;
  logic        read_data;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [11:0] rgb;

  // scanout side
  modport master (
    input  swap_request, read_data,
    output swap, swap_done, read_addr, hsync, vsync, video_on, rgb
  );

  // frame_buffer / drawing / monitor side
  modport slave (
    output swap_request, read_data,
    input  swap, swap_done, read_addr, hsync, vsync, video_on, rgb
  );
endinterface

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA timing and 1-bit front-buffer scanout with vblank-aligned buffer swap
// Optional pixel-clock divider is enabled by defining VGA_SCANOUT_PIXEL_DIV_EN (PIXEL_DIV clks per tick).
module vga_scanout #(
  parameter int          H_VISIBLE = 640,
  parameter int          H_FRONT   = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BACK    = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FRONT   = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BACK    = 33,
  parameter logic [11:0] FG_COLOR  = 12'hFFF,
  parameter logic [11:0] BG_COLOR  = 12'h000,
  parameter int          PIXEL_DIV = 4
) (
  input logic           clk,
  input logic           rst,
  vga_scanout_if.master bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic tick;

`ifdef VGA_SCANOUT_PIXEL_DIV_EN
  localparam int            DW       = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIXEL_DIV - 1);

  logic [DW-1:0] div_cnt;

  // pixel-tick divider: one tick every PIXEL_DIV clocks, restarting from reset
  always_ff @(posedge clk) begin
    if (rst || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == DIV_LAST);
`else
  assign tick = 1'b1;
`endif

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;
  logic          active;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);
  assign active = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  // raster position counters, advancing one pixel per tick
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  logic [18:0] addr_cnt;

  // linear pixel address: counts only across visible pixels, so no y*width multiply is needed
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt <= '0;
    end else if (tick) begin
      if (h_wrap && v_wrap) begin
        addr_cnt <= '0;
      end else if (active) begin
        addr_cnt <= addr_cnt + 19'd1;
      end
    end
  end

  logic [18:0] read_addr_q;
  logic        act_s1;
  logic        hs_s1;
  logic        vs_s1;

  // stage 1: present the address to frame_buffer and register the position flags alongside it
  always_ff @(posedge clk) begin
    if (rst) begin
      read_addr_q <= '0;
      act_s1      <= 1'b0;
      hs_s1       <= 1'b1;
      vs_s1       <= 1'b1;
    end else if (tick) begin
      read_addr_q <= active ? addr_cnt : 19'd0;
      act_s1      <= active;
      hs_s1       <= !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
      vs_s1       <= !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    end
  end

  logic [11:0] rgb_q;
  logic        video_on_q;
  logic        hsync_q;
  logic        vsync_q;

  // stage 2: colour-expand the returned pixel; syncs ride along so everything leaves aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q      <= 12'h000;
      video_on_q <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
    end else if (tick) begin
      rgb_q      <= act_s1 ? (bus.read_data ? FG_COLOR : BG_COLOR) : 12'h000;
      video_on_q <= act_s1;
      hsync_q    <= hs_s1;
      vsync_q    <= vs_s1;
    end
  end

  logic pending;
  logic swap_fire;
  logic swap_q;

  // a request arriving in the fire cycle is absorbed by that fire rather than re-arming pending
  assign swap_fire = tick && (h_cnt == '0) && (v_cnt == V_VIS) && (pending || bus.swap_request);

  // swap request latch and the single-clk swap pulse at the first vblank pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      swap_q  <= 1'b0;
    end else begin
      pending <= (pending || bus.swap_request) && !swap_fire;
      swap_q  <= swap_fire;
    end
  end

  assign bus.read_addr = read_addr_q;
  assign bus.rgb       = rgb_q;
  assign bus.video_on  = video_on_q;
  assign bus.hsync     = hsync_q;
  assign bus.vsync     = vsync_q;
  assign bus.swap      = swap_q;
  assign bus.swap_done = swap_q;

endmodule
